// File: rtl/ring_mem_port_pkg.sv
// Shared ring definitions: slot types, Address opcodes, line geometry and the
// command-queue entry layout used by the cache side and the memory port.
package ring_mem_port_pkg;

  localparam int LINE_WORDS = 8;
  localparam int LINE_IDX_W = 3;

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;
  localparam logic [3:0] SLOT_RDATA = 4'd4;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  localparam logic [3:0] OP_WRITE = 4'b0000;
  localparam logic [3:0] OP_DREAD = 4'b0001;
  localparam logic [3:0] OP_IREAD = 4'b0011;

  typedef struct packed {
    logic        rd;
    logic [27:0] addr;
    logic [3:0]  src;
  } mem_cmd_t;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CMD,
    SEQ_WDATA,
    SEQ_RDATA
  } seq_state_e;

  // D-reads and I-reads are both line reads to memory.
  function automatic logic addr_op_is_read(input logic [3:0] op);
    return (op == OP_DREAD) || (op == OP_IREAD);
  endfunction

endpackage

// File: rtl/ring_cmd_fifo.sv
// Command queue: each entry is a line command plus its 8-word data row.
// A push into a full queue is honoured when a pop happens in the same cycle.
module ring_cmd_fifo
  import ring_mem_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push_i,
  input  mem_cmd_t push_cmd_i,
  input  line_t    push_row_i,
  input  logic     pop_i,
  output logic     empty_o,
  output logic     full_o,
  output logic     drop_o,
  output mem_cmd_t head_cmd_o,
  output line_t    head_row_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  mem_cmd_t      cmd_mem_q [DEPTH];
  line_t         row_mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign drop_o     = push_i && !push_ok;
  assign head_cmd_o = cmd_mem_q[rd_ptr_q];
  assign head_row_o = row_mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      cmd_mem_q[wr_ptr_q] <= push_cmd_i;
      row_mem_q[wr_ptr_q] <= push_row_i;
    end
  end

endmodule

// File: rtl/ring_mem_port.sv
// Ring-snooping memory port: decodes Address/WriteData slots into a command
// queue and sequences line reads/writes to the DDR controller, returning read
// data one cycle after each memory beat.
module ring_mem_port
  import ring_mem_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        memCmdValid,
  input  logic        memCmdReady,
  output logic        memCmdRead,
  output logic [27:0] memCmdAddr,
  output logic [31:0] memWData,
  output logic        memWValid,
  input  logic        memWReady,
  input  logic [31:0] memRData,
  input  logic        memRValid,
  output logic        overflow
);

  logic [LINE_IDX_W-1:0] wcnt_q;
  line_t                 stage_q;
  logic                  overflow_q;
  seq_state_e            state_q, state_d;
  logic [LINE_IDX_W-1:0] bcnt_q, bcnt_d;
  logic [31:0]           rd_data_q;
  logic [3:0]            rd_dest_q;

  logic     is_addr, push_wr, push_rd, push, pop, drop, empty, full, rd_beat;
  mem_cmd_t push_cmd, head_cmd;
  line_t    head_row;

  assign is_addr  = (SlotTypeIn == SLOT_ADDR);
  assign push_wr  = is_addr && (RingIn[31:28] == OP_WRITE);
  assign push_rd  = is_addr && addr_op_is_read(RingIn[31:28]);
  assign push     = push_wr || push_rd;
  assign push_cmd = '{rd: push_rd, addr: RingIn[27:0], src: SourceIn};

  ring_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_cmd_i (push_cmd),
    .push_row_i (stage_q),
    .pop_i      (pop),
    .empty_o    (empty),
    .full_o     (full),
    .drop_o     (drop),
    .head_cmd_o (head_cmd),
    .head_row_o (head_row)
  );

  // Write-data index: advances per WriteData slot, restarts at each write Address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          wcnt_q <= '0;
    else if (push_wr)                   wcnt_q <= '0;
    else if (SlotTypeIn == SLOT_WDATA)  wcnt_q <= wcnt_q + 1'b1;
  end

  // Staging buffer collects the victim line ahead of its write Address.
  always_ff @(posedge clock) begin
    if (SlotTypeIn == SLOT_WDATA) stage_q[wcnt_q] <= RingIn;
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  // Sequencer state and beat counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Sequencer next state and handshake outputs; one command in flight at a time.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    pop         = 1'b0;
    rd_beat     = 1'b0;
    memCmdValid = 1'b0;
    memWValid   = 1'b0;
    case (state_q)
      SEQ_IDLE: if (!empty) state_d = SEQ_CMD;
      SEQ_CMD: begin
        memCmdValid = 1'b1;
        if (memCmdReady) begin
          state_d = head_cmd.rd ? SEQ_RDATA : SEQ_WDATA;
          bcnt_d  = '0;
        end
      end
      SEQ_WDATA: begin
        memWValid = 1'b1;
        if (memWReady) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == LINE_IDX_W'(LINE_WORDS - 1)) begin
            pop     = 1'b1;
            state_d = SEQ_IDLE;
          end
        end
      end
      SEQ_RDATA: begin
        if (memRValid) begin
          rd_beat = 1'b1;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == LINE_IDX_W'(LINE_WORDS - 1)) begin
            pop     = 1'b1;
            state_d = SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Read return: one registered beat per memory beat, zero on all other cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_dest_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_dest_q <= rd_beat ? head_cmd.src : 4'd0;
      rd_data_q <= rd_beat ? memRData : 32'd0;
    end
  end

  assign memCmdRead = head_cmd.rd;
  assign memCmdAddr = head_cmd.addr;
  assign memWData   = head_row[bcnt_q];
  assign RDdest     = rd_dest_q;
  assign RDreturn   = rd_data_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ring_mem_port.sv
// Scoreboard bench for ring_mem_port: stimulus pushes expected commands,
// write beats and read returns; a negedge monitor pops and compares them.
module tb_ring_mem_port;

  localparam logic [3:0] T_TOKEN = 4'd1, T_ADDR = 4'd2, T_WDATA = 4'd3,
                         T_RDATA = 4'd4, T_NULL = 4'd7;

  logic        clock, reset;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SourceIn;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        memCmdValid, memCmdReady, memCmdRead;
  logic [27:0] memCmdAddr;
  logic [31:0] memWData;
  logic        memWValid, memWReady;
  logic [31:0] memRData;
  logic        memRValid;
  logic        overflow;

  ring_mem_port #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .RingIn(RingIn), .SlotTypeIn(SlotTypeIn),
    .SourceIn(SourceIn), .RDreturn(RDreturn), .RDdest(RDdest),
    .memCmdValid(memCmdValid), .memCmdReady(memCmdReady), .memCmdRead(memCmdRead),
    .memCmdAddr(memCmdAddr), .memWData(memWData), .memWValid(memWValid),
    .memWReady(memWReady), .memRData(memRData), .memRValid(memRValid),
    .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0, n_miss = 0;
  logic [28:0] exp_cmd [$];
  logic [31:0] exp_w   [$];
  logic [35:0] exp_rd  [$];

  // responder knobs and state
  bit          cmd_rdy_en = 0, wstall = 0, rgap = 0, spur_rv = 0;
  bit          push_on_last = 0, inj_active = 0;
  int          rd_left = 0;
  logic [27:0] rd_addr = '0;
  logic [31:0] cyc = '0;
  int          rd_seen = 0;
  bit          prev_rv = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] got);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got %0h expected nothing", nm, got);
  endtask

  function automatic logic [31:0] mword(input logic [27:0] a, input int i);
    logic [7:0] ib;
    ib = i[7:0];
    return {a[15:0], 8'hA5, ib};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    SlotTypeIn = t; SourceIn = s; RingIn = d;
    tick();
    SlotTypeIn = T_NULL; SourceIn = 4'd0; RingIn = 32'd0;
  endtask

  task automatic exp_read(input logic [3:0] src, input logic [27:0] a, input int nbeats);
    exp_cmd.push_back({1'b1, a});
    for (int i = 0; i < nbeats; i++) exp_rd.push_back({src, mword(a, i)});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_w.size() != 0 || exp_rd.size() != 0 || rd_left != 0)
           && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) unexp("drain_timeout", 64'(exp_cmd.size() + exp_w.size() + exp_rd.size()));
    repeat (10) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // memory responder: ready patterns and read beats for accepted read commands
  initial begin
    memCmdReady = 1'b0; memWReady = 1'b0; memRValid = 1'b0; memRData = '0;
    forever begin
      tick();
      cyc++;
      memCmdReady = cmd_rdy_en;
      memWReady   = wstall ? cyc[0] : 1'b1;
      if (inj_active) begin
        SlotTypeIn = T_NULL; SourceIn = 4'd0; RingIn = 32'd0;
        inj_active = 0;
      end
      if (reset) begin
        rd_left = 0; memRValid = 1'b0; memRData = '0;
      end else if (rd_left > 0 && !(rgap && cyc[1:0] == 2'b01)) begin
        memRValid = 1'b1;
        memRData  = mword(rd_addr, 8 - rd_left);
        if (rd_left == 1 && push_on_last) begin
          SlotTypeIn = T_ADDR; SourceIn = 4'd9; RingIn = {4'b0001, 28'h0000305};
          push_on_last = 0;
          inj_active = 1;
        end
        rd_left--;
      end else begin
        memRValid = spur_rv;
        memRData  = spur_rv ? 32'hDEAD_BEEF : 32'd0;
      end
    end
  end

  // monitor: pop and compare whenever the DUT presents something
  initial begin
    logic [28:0] ec;
    logic [31:0] ew;
    logic [35:0] er;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (memCmdValid && memCmdReady) begin
          if (exp_cmd.size() == 0) unexp("unexpected_cmd", {memCmdRead, memCmdAddr});
          else begin
            ec = exp_cmd.pop_front();
            chk("cmd", 64'({memCmdRead, memCmdAddr}), 64'(ec));
          end
          if (memCmdRead) begin
            rd_left = 8;
            rd_addr = memCmdAddr;
          end
        end
        if (memWValid && memWReady) begin
          if (exp_w.size() == 0) unexp("unexpected_wbeat", memWData);
          else begin
            ew = exp_w.pop_front();
            chk("wbeat", 64'(memWData), 64'(ew));
          end
        end
        if (RDdest != 4'd0) begin
          rd_seen++;
          chk("rd_latency", 64'(prev_rv), 64'd1);
          if (exp_rd.size() == 0) unexp("unexpected_rdreturn", {RDdest, RDreturn});
          else begin
            er = exp_rd.pop_front();
            chk("rdreturn", 64'({RDdest, RDreturn}), 64'(er));
          end
        end else if (RDreturn != 32'd0) begin
          unexp("rdreturn_without_dest", RDreturn);
        end
      end
      prev_rv = memRValid && !reset;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    reset = 1'b1;
    SlotTypeIn = T_NULL; SourceIn = 4'd0; RingIn = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rddest",   64'(RDdest), 64'd0);
    chk("rst_rdreturn", 64'(RDreturn), 64'd0);
    chk("rst_cmdvalid", 64'(memCmdValid), 64'd0);
    chk("rst_wvalid",   64'(memWValid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    repeat (3) tick();

    // single D-read from core 3
    cmd_rdy_en = 1; rgap = 1;
    exp_read(4'd3, 28'h0001234, 8);
    put(T_ADDR, 4'd3, {4'b0001, 28'h0001234});
    drain();

    // I-read from core 2, then a victim line W0..W7 and its write Address
    wstall = 1;
    exp_read(4'd2, 28'h0000100, 8);
    exp_cmd.push_back({1'b0, 28'h0000040});
    for (int i = 0; i < 8; i++) exp_w.push_back(32'hC0DE_0000 + i);
    put(T_ADDR, 4'd2, {4'b0011, 28'h0000100});
    for (int i = 0; i < 8; i++) put(T_WDATA, 4'd2, 32'hC0DE_0000 + i);
    put(T_ADDR, 4'd2, {4'b0000, 28'h0000040});
    drain();
    wstall = 0; rgap = 0;

    // fill the queue while the controller stalls; fifth Address is dropped
    cmd_rdy_en = 0;
    exp_read(4'd1, 28'h0000200, 8);
    exp_read(4'd4, 28'h0000201, 8);
    exp_cmd.push_back({1'b0, 28'h0000202});
    for (int i = 0; i < 8; i++) exp_w.push_back(32'h1111_0000 + i);
    exp_read(4'd6, 28'h0000203, 8);
    put(T_ADDR, 4'd1, {4'b0001, 28'h0000200});
    put(T_ADDR, 4'd4, {4'b0011, 28'h0000201});
    for (int i = 0; i < 8; i++) put(T_WDATA, 4'd5, 32'h1111_0000 + i);
    put(T_ADDR, 4'd5, {4'b0000, 28'h0000202});
    put(T_ADDR, 4'd6, {4'b0001, 28'h0000203});
    chk("ovf_before_drop", 64'(overflow), 64'd0);
    put(T_ADDR, 4'd7, {4'b0001, 28'h0000204});
    chk("ovf_after_drop", 64'(overflow), 64'd1);
    repeat (5) tick();
    cmd_rdy_en = 1;
    drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    do_reset();
    chk("ovf_cleared_by_reset", 64'(overflow), 64'd0);

    // push in the same cycle as the pop of a full queue
    cmd_rdy_en = 0;
    for (int i = 0; i < 4; i++) begin
      exp_read(4'(i + 1), 28'h0000300 + 28'(i), 8);
      put(T_ADDR, 4'(i + 1), {4'b0001, 28'h0000300 + 28'(i)});
    end
    exp_read(4'd9, 28'h0000305, 8);
    push_on_last = 1;
    repeat (3) tick();
    cmd_rdy_en = 1;
    drain();
    chk("ovf_push_on_pop", 64'(overflow), 64'd0);
    chk("inject_happened", 64'(push_on_last), 64'd0);

    // ignored slots: bad opcode, Token, Null, ReadData, stray memRValid
    spur_rv = 1;
    cnt = 0;
    put(T_ADDR, 4'd3, {4'b0101, 28'h0000777});
    put(T_TOKEN, 4'd3, {4'b0001, 28'h0000778});
    put(T_NULL, 4'd3, {4'b0001, 28'h0000779});
    put(T_RDATA, 4'd3, {4'b0001, 28'h000077A});
    for (int i = 0; i < 20; i++) begin
      if (memCmdValid) cnt++;
      tick();
    end
    chk("ignored_no_cmd", 64'(cnt), 64'd0);
    spur_rv = 0;
    repeat (3) tick();

    // reset during the 4th read beat
    rd_seen = 0;
    exp_read(4'd5, 28'h0000400, 3);
    put(T_ADDR, 4'd5, {4'b0001, 28'h0000400});
    n = 0;
    while (rd_seen < 3 && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (n >= 100) unexp("wait_third_beat_timeout", 64'(rd_seen));
    chk("beat4_rvalid_high", 64'(memRValid), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_rddest",   64'(RDdest), 64'd0);
    chk("midrst_rdreturn", 64'(RDreturn), 64'd0);
    chk("midrst_cmdvalid", 64'(memCmdValid), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (memCmdValid || memWValid) cnt++;
      tick();
    end
    chk("post_rst_idle", 64'(cnt), 64'd0);
    chk("post_rst_exp_empty", 64'(exp_rd.size()), 64'd0);
    exp_read(4'd6, 28'h0000500, 8);
    put(T_ADDR, 4'd6, {4'b0001, 28'h0000500});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
